key_decoder: RTL and testbench



---
 rtl/key_decoder.sv | 156 +++++++++++++++
 tb/tb_key_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_decoder.sv
// PS/2 scan-code-set-2 decoder: tracks E0/F0 prefixes, produces navigation pulses, held levels and last make code.
// Optional build macro KEY_AUTOREPEAT_EN: every make of a mapped key pulses key, including typematic repeats.
module key_decoder #(
    parameter int TIMEOUT_CYCLES = 65000000,
    parameter int CNT_W          = 26
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] keycode,
    output logic [5:0] key,
    output logic [5:0] key_held,
    output logic       seq_error,
    output logic [1:0] state_dbg
);

    // Input handshake: rx_data is sampled on every pclk edge where rx_valid=1.
    // There is no ready; the decoder accepts a byte on every cycle, back-to-back included.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       keycode_n;
    logic [5:0]       key_n;
    logic [5:0]       held_n;
    logic             err_n;
    logic             do_make;
    logic             do_break;
    logic             code_ext;
    logic [5:0]       code_map;

    function automatic logic [5:0] map_code(input logic ext, input logic [7:0] code);
        logic [5:0] m;
        m = 6'b000000;
        if (ext) begin
            case (code)
                8'h75:   m = 6'b000001;
                8'h72:   m = 6'b000010;
                8'h6B:   m = 6'b000100;
                8'h74:   m = 6'b001000;
                default: m = 6'b000000;
            endcase
        end else begin
            case (code)
                8'h5A:   m = 6'b010000;
                8'h76:   m = 6'b100000;
                default: m = 6'b000000;
            endcase
        end
        return m;
    endfunction

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            keycode   <= 8'h00;
            key       <= 6'b000000;
            key_held  <= 6'b000000;
            seq_error <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            keycode   <= keycode_n;
            key       <= key_n;
            key_held  <= held_n;
            seq_error <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        keycode_n = keycode;
        key_n     = 6'b000000;
        held_n    = key_held;
        err_n     = 1'b0;
        do_make   = 1'b0;
        do_break  = 1'b0;
        code_ext  = 1'b0;

        if (rx_valid) begin
            cnt_n = '0;
            case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_n = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_n = BRK;
                    end else if (!(rx_data inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
                        do_make = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        do_make  = 1'b1;
                        code_ext = 1'b1;
                        state_n  = IDLE;
                    end
                end
                BRK: begin
                    do_break = 1'b1;
                    state_n  = IDLE;
                end
                EXT_BRK: begin
                    do_break = 1'b1;
                    code_ext = 1'b1;
                    state_n  = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            // An abandoned prefix leaves keycode/key_held untouched.
            if (cnt == CNT_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
                err_n   = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end

        code_map = map_code(code_ext, rx_data);

        if (do_make) begin
            keycode_n = rx_data;
            held_n    = key_held | code_map;
`ifdef KEY_AUTOREPEAT_EN
            key_n     = code_map;
`else
            key_n     = code_map & ~key_held;
`endif
        end

        if (do_break) begin
            if (rx_data == keycode) begin
                keycode_n = 8'h00;
            end
            held_n = key_held & ~code_map;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_key_decoder.sv
// Directed and randomized bench for key_decoder, checked against a prefix-queue reference model.
module tb_key_decoder;

  localparam int TO = 16;

  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] keycode;
  logic [5:0] key;
  logic [5:0] key_held;
  logic       seq_error;
  logic [1:0] state_dbg;

  always #5 pclk = ~pclk;

  key_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .keycode   (keycode),
    .key       (key),
    .key_held  (key_held),
    .seq_error (seq_error),
    .state_dbg (state_dbg)
  );

  // Reference model: pending prefix bytes kept in a queue, outputs as plain variables.
  logic [7:0] pfx_q[$];
  int         age;
  logic [7:0] m_keycode;
  logic [5:0] m_held;
  logic [5:0] m_key;
  logic       m_err;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int key_index(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end else begin
      if (b == 8'h5A) return 4;
      if (b == 8'h76) return 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pfx_q.delete();
    age       = 0;
    m_keycode = 8'h00;
    m_held    = 6'b000000;
    m_key     = 6'b000000;
    m_err     = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    bit ext;
    m_key = 6'b000000;
    m_err = 1'b0;
    age   = 0;
    if (pfx_q.size() > 0 && pfx_q[$] == 8'hF0) begin
      ext = (pfx_q[0] == 8'hE0);
      pfx_q.delete();
      idx = key_index(ext, b);
      if (b == m_keycode) m_keycode = 8'h00;
      if (idx >= 0) m_held[idx] = 1'b0;
    end else if (b == 8'hE0) begin
      if (pfx_q.size() == 0) pfx_q.push_back(b);
    end else if (b == 8'hF0) begin
      pfx_q.push_back(b);
    end else if (pfx_q.size() == 0 && (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) begin
      m_key = 6'b000000;
    end else begin
      ext = (pfx_q.size() > 0);
      pfx_q.delete();
      idx = key_index(ext, b);
      m_keycode = b;
      if (idx >= 0) begin
`ifdef KEY_AUTOREPEAT_EN
        m_key[idx] = 1'b1;
`else
        if (!m_held[idx]) m_key[idx] = 1'b1;
`endif
        m_held[idx] = 1'b1;
      end
    end
  endtask

  task automatic model_idle();
    m_key = 6'b000000;
    m_err = 1'b0;
    if (pfx_q.size() > 0) begin
      age++;
      if (age == TO) begin
        pfx_q.delete();
        age   = 0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag);
    n_tests++;
    assert (key === m_key) else begin
      n_fail++;
      $error("FAIL %s key: got %b exp %b", tag, key, m_key);
    end
    n_tests++;
    assert (keycode === m_keycode) else begin
      n_fail++;
      $error("FAIL %s keycode: got %h exp %h", tag, keycode, m_keycode);
    end
    n_tests++;
    assert (key_held === m_held) else begin
      n_fail++;
      $error("FAIL %s key_held: got %b exp %b", tag, key_held, m_held);
    end
    n_tests++;
    assert (seq_error === m_err) else begin
      n_fail++;
      $error("FAIL %s seq_error: got %b exp %b", tag, seq_error, m_err);
    end
  endtask

  // Driver tasks start and end at a negedge; outputs are sampled there.
  task automatic send(input logic [7:0] b, input string tag);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
    model_byte(b);
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      model_idle();
      check(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    check(tag);
  endtask

  logic [7:0] pool [16];

  initial begin
    int gap;
    logic [7:0] b;
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'h5A, 8'h76, 8'h1C, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h29};
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge pclk);
    do_reset("reset");

    // Non-extended ENTER make, pulse lasts one cycle.
    send(8'h5A, "enter_make");
    idle(2, "enter_after");
    send(8'hF0, "enter_brk_pfx");
    send(8'h5A, "enter_brk");

    // Extended LEFT make and break.
    send(8'hE0, "left_pfx");
    send(8'h6B, "left_make");
    idle(1, "left_after");
    send(8'hE0, "left_brk_e0");
    send(8'hF0, "left_brk_f0");
    send(8'h6B, "left_brk");

    // Typematic ESC.
    send(8'h76, "esc_1");
    idle(1, "esc_gap");
    send(8'h76, "esc_2");
    idle(1, "esc_gap");
    send(8'h76, "esc_3");
    send(8'hF0, "esc_brk_pfx");
    send(8'h76, "esc_brk");

    // Unmapped key and device responses.
    send(8'h1C, "a_make");
    send(8'hAA, "resp_aa");
    send(8'hFA, "resp_fa");
    send(8'hF0, "a_brk_pfx");
    send(8'h1C, "a_brk");

    // Prefix timeout, then the next byte is a plain make.
    send(8'hE0, "to_pfx");
    idle(TO + 2, "to_wait");
    send(8'h75, "to_after");
    send(8'hF0, "to_rel_pfx");
    send(8'h75, "to_rel");

    // Byte arriving on the timeout cycle wins.
    send(8'hE0, "edge_pfx");
    idle(TO - 1, "edge_wait");
    send(8'h75, "edge_up");
    idle(1, "edge_after");

    // Reset mid-sequence discards the prefix.
    send(8'hE0, "rst_e0");
    send(8'hF0, "rst_f0");
    idle(1, "rst_gap");
    do_reset("rst_mid");
    send(8'h74, "rst_74");

    // Back-to-back strobes.
    send(8'hE0, "b2b_e0");
    send(8'h72, "b2b_down");
    send(8'hE0, "b2b_e0b");
    send(8'hF0, "b2b_f0");
    send(8'h72, "b2b_brk");

    // Randomized traffic with occasional long gaps and resets.
    for (int i = 0; i < 400; i++) begin
      b = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      send(b, "rand_byte");
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) gap = TO + $urandom_range(0, 3) - 2;
      idle(gap, "rand_idle");
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
